cnn_layer_accel_weight_sequencer: RTL and testbench

Control stage directly upstream of the weight sequence table. It generates the `gray_code` phase and `seq_data_addr` stream that the table converts into weight-buffer addresses. It steps a 2-bit Gray-coded phase through 00→01→11→10. Within each phase it walks `C_SEQ_LEN` sequence entries, one per downstream-accepted cycle, for a configured number of full phase cycles. It also emits a valid flag delayed by one cycle so that the flag lines up with the table's registered `wht_data_addr`.

---
 rtl/cnn_layer_accel_weight_sequencer.sv | 149 ++++++++++++++
 tb/tb_cnn_layer_accel_weight_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// rtl/cnn_layer_accel_weight_sequencer.sv - Gray-phase / sequence-address generator feeding the weight sequence table.
// Optional abort input enabled by CNN_LAYER_ACCEL_WHT_SEQ_ABORT_EN.
module cnn_layer_accel_weight_sequencer #(
    parameter int C_SEQ_LEN   = 5,
    parameter int C_CYC_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [C_CYC_WIDTH-1:0] cfg_num_cycles_i,
    input  logic                   advance_i,
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ABORT_EN
    input  logic                   abort_i,
`endif
    output logic [1:0]             gray_code_o,
    output logic [2:0]             seq_data_addr_o,
    output logic                   seq_valid_o,
    output logic                   wht_valid_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam logic [2:0]             LAST_ADDR = 3'(C_SEQ_LEN - 1);
    localparam logic [C_CYC_WIDTH-1:0] CNT_ONE   = C_CYC_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [1:0]             gray_q;
    logic [2:0]             addr_q;
    logic [C_CYC_WIDTH-1:0] cnt_q;
    logic [C_CYC_WIDTH-1:0] num_q;
    logic                   seq_valid_q;
    logic                   wht_valid_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept_d;
    logic                   last_addr_d;
    logic                   last_req_d;
    logic                   abort_d;
    logic [1:0]             gray_next_d;

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ABORT_EN
    assign abort_d = abort_i;
`else
    assign abort_d = 1'b0;
`endif

    // seq_valid_q is only ever set in RUN, so it doubles as the in-RUN qualifier
    assign accept_d    = seq_valid_q & advance_i;
    assign last_addr_d = (addr_q == LAST_ADDR);
    assign last_req_d  = accept_d & last_addr_d & (gray_q == 2'b10)
                       & (cnt_q == (num_q - CNT_ONE));

    always_comb begin
        gray_next_d = 2'b00;
        case (gray_q)
            2'b00:   gray_next_d = 2'b01;
            2'b01:   gray_next_d = 2'b11;
            2'b11:   gray_next_d = 2'b10;
            default: gray_next_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            gray_q      <= 2'b00;
            addr_q      <= 3'd0;
            cnt_q       <= '0;
            num_q       <= '0;
            seq_valid_q <= 1'b0;
            wht_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wht_valid_q <= accept_d;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        gray_q <= 2'b00;
                        addr_q <= 3'd0;
                        cnt_q  <= '0;
                        if (cfg_num_cycles_i != '0) begin
                            num_q       <= cfg_num_cycles_i;
                            seq_valid_q <= 1'b1;
                            state_q     <= S_RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (abort_d) begin
                        seq_valid_q <= 1'b0;
                        gray_q      <= 2'b00;
                        addr_q      <= 3'd0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (last_req_d) begin
                        seq_valid_q <= 1'b0;
                        gray_q      <= 2'b00;
                        addr_q      <= 3'd0;
                        state_q     <= S_DRAIN;
                    end else if (accept_d) begin
                        if (last_addr_d) begin
                            addr_q <= 3'd0;
                            gray_q <= gray_next_d;
                            if (gray_q == 2'b10) begin
                                cnt_q <= cnt_q + CNT_ONE;
                            end
                        end else begin
                            addr_q <= addr_q + 3'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // lets the table's final registered lookup emerge alongside wht_valid
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gray_code_o     = gray_q;
    assign seq_data_addr_o = addr_q;
    assign seq_valid_o     = seq_valid_q;
    assign wht_valid_o     = wht_valid_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
// tb/tb_cnn_layer_accel_weight_sequencer.sv - Scoreboard bench for the weight sequencer.
module tb_cnn_layer_accel_weight_sequencer;

    localparam int LEN = 5;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         advance = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] cfg = '0;
    logic [1:0]   gray;
    logic [2:0]   addr;
    logic         seq_valid;
    logic         wht_valid;
    logic         busy;
    logic         done;

    cnn_layer_accel_weight_sequencer #(.C_SEQ_LEN(LEN), .C_CYC_WIDTH(W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .cfg_num_cycles_i (cfg),
        .advance_i        (advance),
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ABORT_EN
        .abort_i          (abort),
`endif
        .gray_code_o      (gray),
        .seq_data_addr_o  (addr),
        .seq_valid_o      (seq_valid),
        .wht_valid_o      (wht_valid),
        .busy_o           (busy),
        .done_o           (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] g;
        logic [2:0] a;
    } req_t;

    req_t req_q[$];
    int   wht_q[$];
    int   tbl_arr[20];
    logic [1:0] gcode[4];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt = 0, wht_cnt = 0, done_cnt = 0;
    int last_acc_cyc = 0, done_cyc = 0;
    int base_acc, base_wht, base_done;
    int found;
    int tbl_out = 0;
    logic prev_acc = 1'b0, prev_stall = 1'b0;
    logic [1:0] prev_g = 2'b00;
    logic [2:0] prev_a = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int phase_idx(input logic [1:0] g);
        case (g)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int tbl(input logic [1:0] g, input logic [2:0] a);
        return tbl_arr[phase_idx(g) * LEN + int'(a)];
    endfunction

    // stand-in for the downstream table: registered lookup of the presented request
    always @(posedge clk) tbl_out <= tbl(gray, addr);

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_acc   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            req_t r;
            if (prev_stall && seq_valid) begin
                check("stall_gray", gray, prev_g);
                check("stall_addr", addr, prev_a);
            end
            check("wht_align", wht_valid, prev_acc);
            if (seq_valid && advance) begin
                acc_cnt++;
                last_acc_cyc = cyc;
                if (req_q.size() == 0) begin
                    check("req_unexpected", 1, 0);
                end else begin
                    r = req_q.pop_front();
                    check("req_gray", gray, r.g);
                    check("req_addr", addr, r.a);
                end
            end
            if (wht_valid) begin
                wht_cnt++;
                if (wht_q.size() == 0) check("wht_unexpected", 1, 0);
                else check("wht_table", tbl_out, wht_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_acc   = seq_valid && advance;
            prev_stall = seq_valid && !advance;
            prev_g     = gray;
            prev_a     = addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_run();
        req_q.delete();
        wht_q.delete();
        base_acc  = acc_cnt;
        base_wht  = wht_cnt;
        base_done = done_cnt;
    endtask

    task automatic push_reqs(input int n);
        for (int k = 0; k < n; k++) begin
            req_t r;
            r.g = gcode[(k / LEN) % 4];
            r.a = 3'(k % LEN);
            req_q.push_back(r);
            wht_q.push_back(tbl(r.g, r.a));
        end
    endtask

    task automatic issue_start(input int n);
        cfg   = W'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_wait(input bit toggle, output int f);
        f = 0;
        for (int i = 0; i < 2000 && f == 0; i++) begin
            @(negedge clk);
            if (done) f = 1;
            else begin
                @(posedge clk);
                #1;
                if (toggle) advance = ~advance;
            end
        end
    endtask

    task automatic post_checks(input string tag, input int f, input int exp_acc);
        check({tag, "_done_seen"}, f, 1);
        step();
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_done_latency"}, done_cyc - last_acc_cyc, 2);
        check({tag, "_accepts"}, acc_cnt - base_acc, exp_acc);
        check({tag, "_wht_pulses"}, wht_cnt - base_wht, exp_acc);
        check({tag, "_done_once"}, done_cnt - base_done, 1);
        check({tag, "_req_left"}, req_q.size(), 0);
        check({tag, "_wht_left"}, wht_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl_arr = '{2, 3, 7, 8, 9, 7, 8, 9, 2, 3, 4, 5, 6, 2, 3, 0, 1, 7, 8, 9};
        gcode   = '{2'b00, 2'b01, 2'b11, 2'b10};

        repeat (2) @(posedge clk);
        #1;
        check("rst_gray", gray, 0);
        check("rst_addr", addr, 0);
        check("rst_seq_valid", seq_valid, 0);
        check("rst_wht_valid", wht_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // one cycle, continuous advance
        new_run();
        push_reqs(20);
        advance = 1'b1;
        issue_start(1);
        check("t1_seq_valid_first", seq_valid, 1);
        check("t1_busy", busy, 1);
        run_wait(1'b0, found);
        post_checks("t1", found, 20);

        // three cycles with advance toggling
        new_run();
        push_reqs(60);
        advance = 1'b1;
        issue_start(3);
        run_wait(1'b1, found);
        post_checks("t2", found, 60);
        advance = 1'b1;

        // zero count
        new_run();
        issue_start(0);
        check("t3_done", done, 1);
        check("t3_busy", busy, 1);
        check("t3_seq_valid", seq_valid, 0);
        step();
        check("t3_done_clear", done, 0);
        check("t3_busy_clear", busy, 0);
        check("t3_accepts", acc_cnt - base_acc, 0);
        check("t3_done_once", done_cnt - base_done, 1);

        // start pulses during RUN are ignored
        new_run();
        push_reqs(40);
        issue_start(2);
        for (int i = 0; i < 6; i++) begin
            cfg   = W'(7);
            start = 1'b1;
            step();
            start = 1'b0;
            step();
        end
        run_wait(1'b0, found);
        post_checks("t4", found, 40);

        // asynchronous reset mid-phase
        new_run();
        push_reqs(20);
        issue_start(1);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (gray == 2'b11 && addr == 3'd2) found = 1;
        end
        check("t5_reached_mid", found, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_gray", gray, 0);
        check("t5_addr", addr, 0);
        check("t5_seq_valid", seq_valid, 0);
        check("t5_wht_valid", wht_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        req_q.delete();
        wht_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        check("t5_no_done", done_cnt - base_done, 0);
        check("t5_idle", busy, 0);
        new_run();
        push_reqs(20);
        issue_start(1);
        run_wait(1'b0, found);
        post_checks("t5b", found, 20);

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ABORT_EN
        new_run();
        push_reqs(7);
        advance = 1'b1;
        issue_start(1);
        repeat (7) step();
        advance = 1'b0;
        abort   = 1'b1;
        step();
        abort = 1'b0;
        check("t6_done", done, 1);
        check("t6_seq_valid", seq_valid, 0);
        check("t6_gray", gray, 0);
        check("t6_addr", addr, 0);
        step();
        check("t6_idle", busy, 0);
        @(negedge clk);
        #1;
        check("t6_accepts", acc_cnt - base_acc, 7);
        check("t6_wht_pulses", wht_cnt - base_wht, 7);
        check("t6_done_once", done_cnt - base_done, 1);
        check("t6_req_left", req_q.size(), 0);
        advance = 1'b1;
`endif

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
